dm_line_responder: RTL and testbench

- Memory-side responder for the data-cache line interface. It receives the cache's 256-bit line read and write-back requests, waits a programmable latency, then commits the write or returns the line with a one-cycle ack.
- Backs the L1 dcache in place of a bare storage array.
- Adds request counters and an address-range error flag for bench scoreboarding.

---
 rtl/dm_line_responder.sv | 125 ++++++++++++
 tb/tb_dm_line_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_line_responder.sv
// Line-granular memory responder for the data cache: accepts one 256-bit line read or
// write-back at a time, answers after a fixed latency with a one-cycle ack, and keeps scoreboard counters.
module dm_line_responder #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [15:0]       rd_count_o,
    output logic [15:0]       wr_count_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OFF_W = 5;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx_q;
    logic              oor_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  addr_idx;
    logic              addr_oor;
    logic              unused_lo;

    // Byte offset within the line carries no information for a line-granular store.
    assign addr_idx  = addr_i[IDX_W+OFF_W-1:OFF_W];
    assign addr_oor  = |addr_i[ADDR_W-1:IDX_W+OFF_W];
    assign unused_lo = ^addr_i[OFF_W-1:0];

    // Storage is never reset; a write commits on the edge that leaves ACK unless reset aborts it.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state == S_ACK && write_q && !oor_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx_q      <= '0;
            oor_q      <= 1'b0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            ack_o      <= 1'b0;
            data_o     <= '0;
            busy_o     <= 1'b0;
            err_o      <= 1'b0;
            rd_count_o <= '0;
            wr_count_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable_i) begin
                        idx_q   <= addr_idx;
                        oor_q   <= addr_oor;
                        write_q <= write_i;
                        wdata_q <= data_i;
                        busy_o  <= 1'b1;
                        cnt     <= CNT_W'(LATENCY - 1);
                        if (addr_oor) begin
                            err_o <= 1'b1;
                        end
                        if (LATENCY == 1) begin
                            state  <= S_ACK;
                            ack_o  <= 1'b1;
                            data_o <= (!write_i && !addr_oor) ? mem[addr_idx] : '0;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                // The ack cycle begins as the countdown reaches zero.
                S_WAIT: begin
                    if (cnt <= CNT_W'(1)) begin
                        cnt    <= '0;
                        state  <= S_ACK;
                        ack_o  <= 1'b1;
                        data_o <= (!write_q && !oor_q) ? mem[idx_q] : '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_ACK: begin
                    state  <= S_IDLE;
                    ack_o  <= 1'b0;
                    data_o <= '0;
                    busy_o <= 1'b0;
                    if (write_q) begin
                        wr_count_o <= wr_count_o + 16'd1;
                    end else begin
                        rd_count_o <= rd_count_o + 16'd1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    ack_o  <= 1'b0;
                    data_o <= '0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_line_responder.sv
// Bench for dm_line_responder: a LATENCY=10 and a LATENCY=1 instance, vector table,
// hand sequences for hold/abort corners, and random traffic against a line-array model.
module tb_dm_line_responder;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 256;
    localparam int unsigned DEP = 512;
    localparam int unsigned LAT = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          en0, wr0, en1, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] data0, data1, dout0, dout1;
    logic          ack0, busy0, err0, ack1, busy1, err1;
    logic [15:0]   rc0, wc0, rc1, wc1;

    dm_line_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst), .addr_i(addr0), .data_i(data0), .enable_i(en0), .write_i(wr0),
        .ack_o(ack0), .data_o(dout0), .busy_o(busy0), .err_o(err0),
        .rd_count_o(rc0), .wr_count_o(wc0)
    );

    dm_line_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .addr_i(addr1), .data_i(data1), .enable_i(en1), .write_i(wr1),
        .ack_o(ack1), .data_o(dout1), .busy_o(busy1), .err_o(err1),
        .rd_count_o(rc1), .wr_count_o(wc1)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: flat line array plus counters and sticky error.
    logic [DW-1:0] mmem [DEP];
    logic [15:0]   m_rc, m_wc;
    logic          m_err;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          wr;
        logic [DW-1:0] exp_rd;
        logic [15:0]   exp_rc;
        logic [15:0]   exp_wc;
    } vec_t;

    vec_t          tbl [6];
    logic [DW-1:0] r, d, ha, hb, hrd, exp_d, xline;
    int            ack_at [3];
    int            seen, na;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic logic [DW-1:0] rnd256();
        logic [DW-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [DW-1:0] model_op(input logic [AW-1:0] a, input logic [DW-1:0] dd,
                                               input logic w);
        int  idx;
        bit  oor;
        idx = int'((a / 32) % DEP);
        oor = (a >= AW'(DEP * 32));
        if (oor) m_err = 1'b1;
        if (w) begin
            if (!oor) mmem[idx] = dd;
            m_wc = m_wc + 16'd1;
            return '0;
        end
        m_rc = m_rc + 16'd1;
        return oor ? '0 : mmem[idx];
    endfunction

    task automatic drive(input bit sel, input logic e, input logic [AW-1:0] a,
                         input logic [DW-1:0] dd, input logic w);
        if (sel) begin en1 = e; addr1 = a; data1 = dd; wr1 = w; end
        else     begin en0 = e; addr0 = a; data0 = dd; wr0 = w; end
    endtask

    // One request; inputs are scrambled while waiting since only latched values may matter.
    task automatic do_req(input string nm, input bit sel, input logic [AW-1:0] a,
                          input logic [DW-1:0] dd, input logic w, output logic [DW-1:0] rdat);
        int lat;
        int exp_lat;
        exp_lat = sel ? 0 : int'(LAT) - 1;
        lat = -1;
        rdat = '0;
        @(negedge clk);
        drive(sel, 1'b1, a, dd, w);
        for (int j = 0; j < int'(LAT) + 20; j++) begin
            @(negedge clk);
            if ((sel ? ack1 : ack0) === 1'b1) begin
                lat = j;
                rdat = sel ? dout1 : dout0;
                chk({nm, " busy@ack"}, DW'(sel ? busy1 : busy0), DW'(1));
                break;
            end
            drive(sel, 1'b1, $urandom, rnd256(), 1'($urandom));
        end
        drive(sel, 1'b0, '0, '0, 1'b0);
        chk({nm, " latency"}, DW'(lat), DW'(exp_lat));
        @(negedge clk);
        chk({nm, " after ack/busy"}, DW'({sel ? ack1 : ack0, sel ? busy1 : busy0}), DW'(0));
        chk({nm, " after data"}, sel ? dout1 : dout0, '0);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk({nm, " dut status"}, DW'({ack0, busy0, err0, rc0, wc0}), DW'(0));
        chk({nm, " dut data"}, dout0, '0);
        chk({nm, " dut1 status"}, DW'({ack1, busy1, err1, rc1, wc1, dout1}), DW'(0));
        m_rc = '0;
        m_wc = '0;
        m_err = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{32'h0000_0000, '0,               1'b0, 256'h5,           16'd1, 16'd0};
        tbl[1] = '{32'h0000_0400, 256'hDEAD_BEEF,   1'b1, '0,               16'd1, 16'd1};
        tbl[2] = '{32'h0000_0400, '0,               1'b0, 256'hDEAD_BEEF,   16'd2, 16'd1};
        tbl[3] = '{32'h0000_041F, '0,               1'b0, 256'hDEAD_BEEF,   16'd3, 16'd1};
        tbl[4] = '{32'h0000_0060, {4{64'hCAFE_F00D_1234_5678}}, 1'b1, '0,   16'd3, 16'd2};
        tbl[5] = '{32'h0000_007F, '0,               1'b0, {4{64'hCAFE_F00D_1234_5678}}, 16'd4, 16'd2};

        rst = 1'b1;
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0);
        do_reset("reset0");

        // Fill every line so later reads have known contents; line 0 holds 5.
        for (int i = 0; i < int'(DEP); i++) begin
            d = (i == 0) ? DW'(5) : rnd256();
            void'(model_op(AW'(i * 32), d, 1'b1));
            do_req("preload", 0, AW'(i * 32), d, 1'b1, r);
        end
        chk("preload wr_count", DW'(wc0), DW'(DEP));
        do_reset("reset1");

        for (int k = 0; k < 6; k++) begin
            exp_d = model_op(tbl[k].addr, tbl[k].data, tbl[k].wr);
            do_req($sformatf("vec%0d", k), 0, tbl[k].addr, tbl[k].data, tbl[k].wr, r);
            chk($sformatf("vec%0d data", k), r, tbl[k].wr ? '0 : tbl[k].exp_rd);
            chk($sformatf("vec%0d counts", k), DW'({rc0, wc0}), DW'({tbl[k].exp_rc, tbl[k].exp_wc}));
        end

        // enable held across three requests; accepts land every LAT+1 negedges.
        ha = rnd256();
        hb = rnd256();
        hrd = '0;
        na = 0;
        for (int k = 0; k < 3; k++) ack_at[k] = -1;
        @(negedge clk);
        for (int n = 0; n < 34; n++) begin
            if (n > 0) @(negedge clk);
            if (ack0 === 1'b1) begin
                if (na < 3) ack_at[na] = n;
                na++;
                if (n == 32) hrd = dout0;
            end
            if (n == 0)       drive(0, 1'b1, 32'h0000_0080, ha, 1'b1);
            else if (n == 11) drive(0, 1'b1, 32'h0000_00A0, hb, 1'b1);
            else if (n == 22) drive(0, 1'b1, 32'h0000_008F, rnd256(), 1'b0);
            else if (n == 33) drive(0, 1'b0, '0, '0, 1'b0);
            else              drive(0, 1'b1, $urandom, rnd256(), 1'($urandom));
        end
        void'(model_op(32'h0000_0080, ha, 1'b1));
        void'(model_op(32'h0000_00A0, hb, 1'b1));
        exp_d = model_op(32'h0000_008F, '0, 1'b0);
        chk("hold ack count", DW'(na), DW'(3));
        chk("hold ack0 time", DW'(ack_at[0]), DW'(LAT));
        chk("hold ack1 time", DW'(ack_at[1]), DW'(2 * LAT + 1));
        chk("hold ack2 time", DW'(ack_at[2]), DW'(3 * LAT + 2));
        chk("hold read data", hrd, exp_d);
        exp_d = model_op(32'h0000_00A0, '0, 1'b0);
        do_req("hold readback", 0, 32'h0000_00A0, '0, 1'b0, r);
        chk("hold readback data", r, exp_d);
        chk("hold counts", DW'({rc0, wc0}), DW'({m_rc, m_wc}));

        // Reset five cycles into a write to line 2 must abort it entirely.
        @(negedge clk);
        drive(0, 1'b1, 32'h0000_0040, rnd256(), 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        m_rc = '0;
        m_wc = '0;
        m_err = 1'b0;
        seen = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (ack0 === 1'b1) seen++;
        end
        chk("abort no ack", DW'(seen), DW'(0));
        chk("abort status", DW'({busy0, err0, rc0, wc0}), DW'(0));
        exp_d = model_op(32'h0000_0040, '0, 1'b0);
        do_req("abort line2", 0, 32'h0000_0040, '0, 1'b0, r);
        chk("abort line2 data", r, exp_d);
        exp_d = model_op(32'h0000_0080, '0, 1'b0);
        do_req("abort line4", 0, 32'h0000_0080, '0, 1'b0, r);
        chk("abort line4 data", r, exp_d);

        // Random traffic, roughly one in eight out of range.
        for (int k = 0; k < 40; k++) begin
            logic [AW-1:0] a;
            logic          w;
            a = {(($urandom % 8) == 0) ? 18'($urandom_range(1, 262143)) : 18'd0,
                 9'($urandom % DEP), 5'($urandom)};
            w = 1'($urandom);
            d = rnd256();
            exp_d = model_op(a, d, w);
            do_req($sformatf("rnd%0d", k), 0, a, d, w, r);
            chk($sformatf("rnd%0d data", k), r, exp_d);
            chk($sformatf("rnd%0d counts", k), DW'({rc0, wc0}), DW'({m_rc, m_wc}));
            chk($sformatf("rnd%0d err", k), DW'(err0), DW'(m_err));
        end

        // Single-cycle-latency instance, including out-of-range handling.
        xline = rnd256();
        do_req("l1 write", 1, 32'h0000_0060, xline, 1'b1, r);
        do_req("l1 read", 1, 32'h0000_0060, '0, 1'b0, r);
        chk("l1 read data", r, xline);
        chk("l1 err clean", DW'(err1), DW'(0));
        do_req("l1 oor read", 1, 32'h0010_0000, '0, 1'b0, r);
        chk("l1 oor data", r, '0);
        chk("l1 oor err", DW'(err1), DW'(1));
        do_req("l1 oor write", 1, 32'h0010_0060, rnd256(), 1'b1, r);
        do_req("l1 reread", 1, 32'h0000_0060, '0, 1'b0, r);
        chk("l1 reread data", r, xline);
        chk("l1 err sticky", DW'(err1), DW'(1));
        chk("l1 counts", DW'({rc1, wc1}), DW'({16'd3, 16'd2}));

        do_reset("reset_final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
